// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit and the stage datapaths:
// result classes, Tnew/Tuse constants, mux select codes and the shadow entry type.
package fwd_hazard_unit_pkg;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2
    } src_t;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_E_ALU  = 2'd1;
    localparam logic [1:0] TNEW_E_MEM  = 2'd2;
    localparam logic [1:0] TNEW_E_LINK = 2'd0;

    // Compare/ALU operand selects (ALU side only ever uses 0-5)
    localparam logic [2:0] SEL_RD      = 3'd0;
    localparam logic [2:0] SEL_MEMRD_W = 3'd1;
    localparam logic [2:0] SEL_RES_W   = 3'd2;
    localparam logic [2:0] SEL_RES_M   = 3'd3;
    localparam logic [2:0] SEL_PC8_W   = 3'd4;
    localparam logic [2:0] SEL_PC8_M   = 3'd5;
    localparam logic [2:0] SEL_PC8_E   = 3'd6;

    // M-stage store-data selects
    localparam logic [1:0] WD_RD2      = 2'd0;
    localparam logic [1:0] WD_MEMRD_W  = 2'd1;
    localparam logic [1:0] WD_RES_W    = 2'd2;
    localparam logic [1:0] WD_PC8_W    = 2'd3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        src_t       src;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{rs: 5'd0, rt: 5'd0, a3: 5'd0, tnew: 2'd0, src: SRC_ALU};

    function automatic logic [1:0] tnew_at_e(input src_t src);
        case (src)
            SRC_ALU:  return TNEW_E_ALU;
            SRC_MEM:  return TNEW_E_MEM;
            default:  return TNEW_E_LINK;
        endcase
    endfunction

    function automatic stage_t advance(input stage_t s);
        stage_t r;
        r = s;
        r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
        return r;
    endfunction

    // Youngest E/M producer of r decides; a result not ready by Tuse stalls D.
    function automatic logic hazard(input logic [4:0] r, input logic [1:0] tuse,
                                    input stage_t e, input stage_t m);
        logic       hit;
        logic [1:0] tn;
        hit = 1'b0;
        tn  = 2'd0;
        if (r != 5'd0 && tuse != TUSE_NONE) begin
            if (e.a3 == r) begin
                hit = 1'b1;
                tn  = e.tnew;
            end else if (m.a3 == r) begin
                hit = 1'b1;
                tn  = m.tnew;
            end
        end
        return hit && (tn > tuse);
    endfunction

    // Store-data mux only sees W, so W-only codes fold into its 2-bit encoding.
    function automatic logic [1:0] wd_from_sel(input logic [2:0] sel);
        case (sel)
            SEL_MEMRD_W: return WD_MEMRD_W;
            SEL_RES_W:   return WD_RES_W;
            SEL_PC8_W:   return WD_PC8_W;
            default:     return WD_RD2;
        endcase
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// One forwarding select: youngest matching producer among enabled E/M and W wins;
// a producer whose result is not yet ready yields the plain register-file path.
module fwd_sel
    import fwd_hazard_unit_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic       en_e,
    input  logic       en_m,
    input  logic [4:0] e_a3,
    input  logic [1:0] e_tnew,
    input  logic [1:0] e_src,
    input  logic [4:0] m_a3,
    input  logic [1:0] m_tnew,
    input  logic [1:0] m_src,
    input  logic [4:0] w_a3,
    input  logic [1:0] w_tnew,
    input  logic [1:0] w_src,
    output logic [2:0] sel
);

    always_comb begin
        sel = SEL_RD;
        if (src_reg != 5'd0) begin
            if (en_e && e_a3 == src_reg) begin
                if (e_tnew == 2'd0 && e_src == SRC_LINK) sel = SEL_PC8_E;
            end else if (en_m && m_a3 == src_reg) begin
                if (m_tnew == 2'd0) begin
                    case (m_src)
                        SRC_ALU:  sel = SEL_RES_M;
                        SRC_LINK: sel = SEL_PC8_M;
                        default:  sel = SEL_RD;
                    endcase
                end
            end else if (w_a3 == src_reg) begin
                if (w_tnew == 2'd0) begin
                    case (w_src)
                        SRC_ALU:  sel = SEL_RES_W;
                        SRC_MEM:  sel = SEL_MEMRD_W;
                        SRC_LINK: sel = SEL_PC8_W;
                        default:  sel = SEL_RD;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadows E/M/W destination/Tnew state and
// produces the D stall plus all bypass mux selects combinationally.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [1:0] TuseRsD,
    input  logic [1:0] TuseRtD,
    input  logic [4:0] A3D,
    input  logic [1:0] SrcD,
    output logic       StallD,
    output logic [2:0] MCMPA,
    output logic [2:0] MCMPB,
    output logic [2:0] MALUAE,
    output logic [2:0] MALUBE,
    output logic [1:0] MWDM
);

    localparam int N_SEL = 5;

    stage_t e_q, m_q, w_q;
    stage_t e_d, m_d, w_d;

    logic [4:0] sel_reg [N_SEL];
    logic [N_SEL-1:0] sel_en_e;
    logic [N_SEL-1:0] sel_en_m;
    logic [2:0] sel [N_SEL];

    logic unused_w_regs;
    assign unused_w_regs = ^{w_q.rs, w_q.rt};

    assign StallD = hazard(RsD, TuseRsD, e_q, m_q) | hazard(RtD, TuseRtD, e_q, m_q);

    always_comb begin
        if (StallD) begin
            e_d = STAGE_BUBBLE;
        end else begin
            e_d.rs   = RsD;
            e_d.rt   = RtD;
            e_d.a3   = A3D;
            e_d.src  = src_t'(SrcD);
            e_d.tnew = tnew_at_e(src_t'(SrcD));
        end
        m_d = advance(e_q);
        w_d = advance(m_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= STAGE_BUBBLE;
            m_q <= STAGE_BUBBLE;
            w_q <= STAGE_BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    // Slots: 0/1 D compare operands, 2/3 E ALU operands, 4 M store data.
    always_comb begin
        sel_reg[0] = RsD;     sel_en_e[0] = 1'b1; sel_en_m[0] = 1'b1;
        sel_reg[1] = RtD;     sel_en_e[1] = 1'b1; sel_en_m[1] = 1'b1;
        sel_reg[2] = e_q.rs;  sel_en_e[2] = 1'b0; sel_en_m[2] = 1'b1;
        sel_reg[3] = e_q.rt;  sel_en_e[3] = 1'b0; sel_en_m[3] = 1'b1;
        sel_reg[4] = m_q.rt;  sel_en_e[4] = 1'b0; sel_en_m[4] = 1'b0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SEL; gi++) begin : g_sel
            fwd_sel u_fwd_sel (
                .src_reg (sel_reg[gi]),
                .en_e    (sel_en_e[gi]),
                .en_m    (sel_en_m[gi]),
                .e_a3    (e_q.a3),
                .e_tnew  (e_q.tnew),
                .e_src   (e_q.src),
                .m_a3    (m_q.a3),
                .m_tnew  (m_q.tnew),
                .m_src   (m_q.src),
                .w_a3    (w_q.a3),
                .w_tnew  (w_q.tnew),
                .w_src   (w_q.src),
                .sel     (sel[gi])
            );
        end
    endgenerate

    assign MCMPA  = sel[0];
    assign MCMPB  = sel[1];
    assign MALUAE = sel[2];
    assign MALUBE = sel[3];
    assign MWDM   = wd_from_sel(sel[4]);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: short instruction sequences driven into D,
// stall and select outputs checked against hand-derived values each cycle.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       reset;
    logic [4:0] RsD, RtD, A3D;
    logic [1:0] TuseRsD, TuseRtD, SrcD;
    logic       StallD;
    logic [2:0] MCMPA, MCMPB, MALUAE, MALUBE;
    logic [1:0] MWDM;

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_unit dut (
        .clk     (clk),
        .reset   (reset),
        .RsD     (RsD),
        .RtD     (RtD),
        .TuseRsD (TuseRsD),
        .TuseRtD (TuseRtD),
        .A3D     (A3D),
        .SrcD    (SrcD),
        .StallD  (StallD),
        .MCMPA   (MCMPA),
        .MCMPB   (MCMPB),
        .MALUAE  (MALUAE),
        .MALUBE  (MALUBE),
        .MWDM    (MWDM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic d_set(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tus,
                         input logic [1:0] tut, input logic [4:0] a3, input logic [1:0] src);
        RsD = rs; RtD = rt; TuseRsD = tus; TuseRtD = tut; A3D = a3; SrcD = src;
    endtask

    task automatic d_idle();
        d_set(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
    endtask

    // Sample between edges, then advance to just after the next rising edge.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        d_idle();
        repeat (3) adv();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"},  {7'd0, StallD}, 8'd0);
        check({tag, ".mcmpa"},  {5'd0, MCMPA},  8'd0);
        check({tag, ".mcmpb"},  {5'd0, MCMPB},  8'd0);
        check({tag, ".maluae"}, {5'd0, MALUAE}, 8'd0);
        check({tag, ".malube"}, {5'd0, MALUBE}, 8'd0);
        check({tag, ".mwdm"},   {6'd0, MWDM},   8'd0);
    endtask

    initial begin
        reset = 1'b1;
        d_idle();
        mid();
        check_all_zero("reset");
        adv();
        reset = 1'b0;
        mid();
        check_all_zero("idle");
        adv();

        // lw $8 ; add $10,$8,$11 (Tuse 1): one stall, then MEM forward at E
        d_set(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd1);
        mid(); check("lwadd.c1.stall", {7'd0, StallD}, 8'd0); adv();
        d_set(5'd8, 5'd11, 2'd1, 2'd1, 5'd10, 2'd0);
        mid(); check("lwadd.c2.stall", {7'd0, StallD}, 8'd1); adv();
        mid(); check("lwadd.c3.stall", {7'd0, StallD}, 8'd0);
               check("lwadd.c3.mcmpa", {5'd0, MCMPA}, 8'd0); adv();
        d_idle();
        mid(); check("lwadd.c4.maluae", {5'd0, MALUAE}, 8'd1);
               check("lwadd.c4.malube", {5'd0, MALUBE}, 8'd0); adv();
        flush();

        // lw $8 ; beq $8 (Tuse 0): two stalls, then load data from W
        d_set(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd1);
        adv();
        d_set(5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0);
        mid(); check("lwbeq.c2.stall", {7'd0, StallD}, 8'd1); adv();
        mid(); check("lwbeq.c3.stall", {7'd0, StallD}, 8'd1); adv();
        mid(); check("lwbeq.c4.stall", {7'd0, StallD}, 8'd0);
               check("lwbeq.c4.mcmpa", {5'd0, MCMPA}, 8'd1); adv();
        flush();

        // addu $9 ; beq $9: one stall, then ALU result from M
        d_set(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd0);
        adv();
        d_set(5'd9, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        mid(); check("addbeq.c2.stall", {7'd0, StallD}, 8'd1); adv();
        mid(); check("addbeq.c3.stall", {7'd0, StallD}, 8'd0);
               check("addbeq.c3.mcmpa", {5'd0, MCMPA}, 8'd3); adv();
        flush();

        // addu $9 ; indep ; beq $9: producer already at M with result ready
        d_set(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd0); adv();
        d_set(5'd3, 5'd4, 2'd1, 2'd1, 5'd12, 2'd0); adv();
        d_set(5'd9, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        mid(); check("add1beq.stall", {7'd0, StallD}, 8'd0);
               check("add1beq.mcmpa", {5'd0, MCMPA}, 8'd3); adv();
        flush();

        // addu $9 ; indep ; indep ; beq $9: producer at W
        d_set(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd0); adv();
        d_set(5'd3, 5'd4, 2'd1, 2'd1, 5'd12, 2'd0); adv();
        d_set(5'd5, 5'd6, 2'd1, 2'd1, 5'd13, 2'd0); adv();
        d_set(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd0);
        mid(); check("add2beq.stall", {7'd0, StallD}, 8'd0);
               check("add2beq.mcmpb", {5'd0, MCMPB}, 8'd2); adv();
        flush();

        // jal ; use $31 at D ; second use: PC+8 from E, then M, then W
        d_set(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd2); adv();
        d_set(5'd31, 5'd0, 2'd0, 2'd3, 5'd5, 2'd0);
        mid(); check("jal.c2.stall", {7'd0, StallD}, 8'd0);
               check("jal.c2.mcmpa", {5'd0, MCMPA}, 8'd6); adv();
        d_set(5'd31, 5'd0, 2'd1, 2'd3, 5'd6, 2'd0);
        mid(); check("jal.c3.maluae", {5'd0, MALUAE}, 8'd5);
               check("jal.c3.mcmpa", {5'd0, MCMPA}, 8'd5); adv();
        d_idle();
        mid(); check("jal.c4.maluae", {5'd0, MALUAE}, 8'd4); adv();
        flush();

        // jal ; sw $31: store data follows the link value down to M
        d_set(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd2); adv();
        d_set(5'd29, 5'd31, 2'd1, 2'd2, 5'd0, 2'd0);
        mid(); check("jalsw.c2.mcmpb", {5'd0, MCMPB}, 8'd6); adv();
        d_idle();
        mid(); check("jalsw.c3.malube", {5'd0, MALUBE}, 8'd5); adv();
        mid(); check("jalsw.c4.mwdm", {6'd0, MWDM}, 8'd3); adv();
        flush();

        // addu $9 ; sw $9 (Tuse 2): no stall, ALU result forwarded at E then W
        d_set(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd0); adv();
        d_set(5'd29, 5'd9, 2'd1, 2'd2, 5'd0, 2'd0);
        mid(); check("addsw.c2.stall", {7'd0, StallD}, 8'd0);
               check("addsw.c2.mcmpb", {5'd0, MCMPB}, 8'd0); adv();
        d_idle();
        mid(); check("addsw.c3.malube", {5'd0, MALUBE}, 8'd3); adv();
        mid(); check("addsw.c4.mwdm", {6'd0, MWDM}, 8'd2); adv();
        flush();

        // lw $8 ; sw $8: load data reaches store only at M from W
        d_set(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd1); adv();
        d_set(5'd29, 5'd8, 2'd1, 2'd2, 5'd0, 2'd0);
        mid(); check("lwsw.c2.stall", {7'd0, StallD}, 8'd0); adv();
        d_idle();
        mid(); check("lwsw.c3.malube", {5'd0, MALUBE}, 8'd0); adv();
        mid(); check("lwsw.c4.mwdm", {6'd0, MWDM}, 8'd1); adv();
        flush();

        // lw $0 ; beq $0: register zero never stalls or forwards
        d_set(5'd29, 5'd0, 2'd1, 2'd3, 5'd0, 2'd1); adv();
        d_set(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        mid(); check_all_zero("zero.c2"); adv();
        mid(); check_all_zero("zero.c3"); adv();
        flush();

        // Reset asserted during a load-use stall clears state immediately
        d_set(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd1); adv();
        d_set(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
        mid(); check("rststall.pre", {7'd0, StallD}, 8'd1);
        #2 reset = 1'b1;
        #1 check("rststall.async", {7'd0, StallD}, 8'd0);
        check("rststall.mcmpa", {5'd0, MCMPA}, 8'd0);
        adv();
        reset = 1'b0;
        mid(); check("rststall.rel.stall", {7'd0, StallD}, 8'd0); adv();
        d_idle();
        mid(); check_all_zero("rststall.post"); adv();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
